// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared encodings and helpers for the Z80 bus arbiter
package z80_bus_pkg;

  localparam int ARB_MAX_MASTERS = 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_CPU = 3'd1;
  localparam logic [2:0] GRANT   = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] HOLDOFF = 3'd4;

  // A single master still needs a 1-bit owner field.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/busarb_rr_pick.sv
// rtl/busarb_rr_pick.sv - combinational round-robin picker
// Searches upward from ptr with wrap; req is active high and already masked.
module busarb_rr_pick
  import z80_bus_pkg::*;
#(
  parameter int N = 2,
  parameter int W = owner_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [N-1:0] rot;
  logic [W:0]   off;
  logic [W:0]   sum;

  // Rotating by ptr turns the search into a lowest-set-bit scan.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    off   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        off   = (W+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= N_W) sum = sum - N_W;
    winner = sum[W-1:0];
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - BUSRQ/BUSAK arbiter between the TV80 and N bus masters
// Define ARB_TIMEOUT_EN to build the MAX_HOLD watchdog and per-master block mask.
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  parameter int  CPU_SLOT  = 8,
  parameter int  MAX_HOLD  = 255,
  localparam int OW        = owner_width(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_MASTERS-1:0] req_n,
  output logic [N_MASTERS-1:0] ack_n,
  output logic                 cpu_busrq_n,
  input  logic                 cpu_busak_n,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int          SW  = (CPU_SLOT > 1) ? $clog2(CPU_SLOT) : 1;
  localparam logic [OW:0] N_W = (OW+1)'(N_MASTERS);

  logic [2:0]           state;
  logic [2:0]           state_d;
  logic [OW-1:0]        owner_q;
  logic [OW-1:0]        ptr_q;
  logic [OW-1:0]        winner;
  logic [OW-1:0]        winner_inc;
  logic [OW:0]          winner_sum;
  logic                 pick_valid;
  logic [N_MASTERS-1:0] owner_oh;
  logic [N_MASTERS-1:0] block_mask;
  logic [N_MASTERS-1:0] req_act;
  logic                 own_req_n;
  logic                 hold_expired;
  logic [SW-1:0]        slot_cnt;

  assign owner_oh  = N_MASTERS'(1) << owner_q;
  assign own_req_n = |(req_n & owner_oh);
  assign req_act   = ~req_n & ~block_mask;

  busarb_rr_pick #(
    .N (N_MASTERS),
    .W (OW)
  ) u_pick (
    .req    (req_act),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (pick_valid)
  );

  // With one master this always wraps to 0, so the pointer stays constant.
  assign winner_sum = {1'b0, winner} + (OW+1)'(1);
  assign winner_inc = (winner_sum >= N_W) ? '0 : winner_sum[OW-1:0];

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          timeout_q;
  logic          reclaim;

  // Fires on the edge that would take the count to MAX_HOLD: ack lasts MAX_HOLD cycles.
  assign hold_expired = (hold_cnt >= HW'(MAX_HOLD - 1));
  assign reclaim      = (state == GRANT) && !own_req_n && hold_expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt   <= '0;
      timeout_q  <= 1'b0;
      block_mask <= '0;
    end else begin
      timeout_q  <= reclaim;
      block_mask <= (block_mask & ~req_n) | (reclaim ? owner_oh : '0);
      if (state == REQ_CPU)
        hold_cnt <= '0;
      else if ((state == GRANT) && (hold_cnt != '1))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign block_mask   = '0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_valid) state_d = REQ_CPU;
      REQ_CPU: begin
        if (own_req_n)         state_d = RELEASE;
        else if (!cpu_busak_n) state_d = GRANT;
      end
      GRANT:   if (own_req_n || hold_expired) state_d = RELEASE;
      RELEASE: if (cpu_busak_n) state_d = (CPU_SLOT == 0) ? IDLE : HOLDOFF;
      HOLDOFF: if (slot_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= '0;
      ptr_q    <= '0;
      slot_cnt <= '0;
    end else begin
      if ((state == IDLE) && pick_valid) begin
        owner_q <= winner;
        ptr_q   <= winner_inc;
      end
      if ((state == RELEASE) && cpu_busak_n)
        slot_cnt <= SW'((CPU_SLOT > 0) ? CPU_SLOT - 1 : 0);
      else if ((state == HOLDOFF) && (slot_cnt != '0))
        slot_cnt <= slot_cnt - 1'b1;
    end
  end

  // Bus outputs decode straight from the async-reset state, so reset frees the bus at once.
  always_comb begin
    busy        = (state != IDLE) && (state != HOLDOFF);
    cpu_busrq_n = !((state == REQ_CPU) || (state == GRANT));
    ack_n       = (state == GRANT) ? ~owner_oh : '1;
    owner       = owner_q;
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - directed self-checking bench for z80_bus_arbiter
`timescale 1ns/1ps
module tb_z80_bus_arbiter;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;

  logic [1:0] req_a   = 2'b11;
  logic [1:0] ack_a;
  logic       busrq_a;
  logic       busak_a = 1'b1;
  logic [0:0] owner_a;
  logic       busy_a;
  logic       to_a;

  logic [1:0] req_b   = 2'b11;
  logic [1:0] ack_b;
  logic       busrq_b;
  logic       busak_b = 1'b1;
  logic [0:0] owner_b;
  logic       busy_b;
  logic       to_b;

  logic       cpu_en  = 1'b1;
  logic       a_d1    = 1'b1;
  logic       b_d1    = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // CPU models: BUSAK follows BUSRQ two falling edges later; cpu_en=0 withholds BUSAK on A.
  always @(negedge clk) begin
    a_d1    <= busrq_a | ~cpu_en;
    busak_a <= a_d1;
    b_d1    <= busrq_b;
    busak_b <= b_d1;
  end

  z80_bus_arbiter #(.N_MASTERS(2), .CPU_SLOT(8), .MAX_HOLD(16)) u_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_n       (req_a),
    .ack_n       (ack_a),
    .cpu_busrq_n (busrq_a),
    .cpu_busak_n (busak_a),
    .owner       (owner_a),
    .busy        (busy_a),
    .timeout     (to_a)
  );

  z80_bus_arbiter #(.N_MASTERS(2), .CPU_SLOT(0), .MAX_HOLD(16)) u_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_n       (req_b),
    .ack_n       (ack_b),
    .cpu_busrq_n (busrq_b),
    .cpu_busak_n (busak_b),
    .owner       (owner_b),
    .busy        (busy_b),
    .timeout     (to_b)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input string tag);
    int n = 0;
    while (ack_a == 2'b11 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(ack_a != 2'b11), 32'd1);
  endtask

  // Cycles with busy low between a release and the next request: HOLDOFF plus the IDLE pick cycle.
  task automatic gap_a(output int n);
    int g = 0;
    n = 0;
    while (busy_a && g < 20) begin
      tick();
      g++;
    end
    while (!busy_a && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int regrant;

    #2;
    chk("rst_ack",   32'(ack_a),   32'(2'b11));
    chk("rst_busrq", 32'(busrq_a), 32'd1);
    chk("rst_owner", 32'(owner_a), 32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_to",    32'(to_a),    32'd0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // single master 0
    req_a = 2'b10;
    tick();
    chk("single_busrq",   32'(busrq_a), 32'd0);
    chk("single_busy",    32'(busy_a),  32'd1);
    chk("single_noack",   32'(ack_a),   32'(2'b11));
    tick();
    chk("single_waitack", 32'(ack_a),   32'(2'b11));
    tick();
    chk("single_ack",     32'(ack_a),   32'(2'b10));
    chk("single_owner",   32'(owner_a), 32'd0);
    tick();
    chk("single_hold",    32'(ack_a),   32'(2'b10));
    req_a = 2'b11;
    tick();
    chk("single_rel_ack",   32'(ack_a),   32'(2'b11));
    chk("single_rel_busrq", 32'(busrq_a), 32'd1);
    tick(12);

    // abort: master 1 withdraws before BUSAK
    cpu_en = 1'b0;
    req_a  = 2'b01;
    tick();
    chk("abort_busrq", 32'(busrq_a), 32'd0);
    chk("abort_owner", 32'(owner_a), 32'd1);
    tick(3);
    chk("abort_noack", 32'(ack_a),   32'(2'b11));
    req_a = 2'b11;
    tick();
    chk("abort_rel_busrq", 32'(busrq_a), 32'd1);
    chk("abort_rel_ack",   32'(ack_a),   32'(2'b11));
    tick();
    chk("abort_holdoff",   32'(busy_a),  32'd0);
    tick(12);
    cpu_en = 1'b1;

    // contention: pointer is back at 0, so grants go 0,1,0,1
    req_a = 2'b00;
    for (int g = 0; g < 4; g++) begin
      wait_a("cont_grant");
      chk("cont_ack",   32'(ack_a),   32'((g % 2 == 0) ? 2'b10 : 2'b01));
      chk("cont_owner", 32'(owner_a), 32'(g % 2));
      if (g < 3) begin
        tick(2);
        req_a = (g % 2 == 0) ? 2'b01 : 2'b10;
        tick();
        chk("cont_rel_ack",   32'(ack_a),   32'(2'b11));
        chk("cont_rel_busrq", 32'(busrq_a), 32'd1);
        req_a = 2'b00;
        gap_a(n);
        chk("cont_gap", 32'(n), 32'd9);
      end
    end

    // reset mid-grant while master 1 owns the bus
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_ack",   32'(ack_a),   32'(2'b11));
    chk("mrst_busrq", 32'(busrq_a), 32'd1);
    chk("mrst_owner", 32'(owner_a), 32'd0);
    chk("mrst_busy",  32'(busy_a),  32'd0);
    req_a = 2'b11;
    tick(3);
    reset_n = 1'b1;
    tick(3);

    // master 0 keeps requesting
    req_a = 2'b10;
    wait_a("wd_grant");
    n = 1;
    tick();
`ifdef ARB_TIMEOUT_EN
    while (ack_a == 2'b10 && n < 300) begin
      n++;
      tick();
    end
    chk("wd_len",   32'(n),       32'd16);
    chk("wd_pulse", 32'(to_a),    32'd1);
    chk("wd_busrq", 32'(busrq_a), 32'd1);
    tick();
    chk("wd_pulse_end", 32'(to_a), 32'd0);
    regrant = 0;
    repeat (40) begin
      tick();
      if (ack_a != 2'b11) regrant++;
    end
    chk("wd_masked",      32'(regrant), 32'd0);
    chk("wd_masked_busy", 32'(busy_a),  32'd0);
    req_a = 2'b11;
    tick();
    req_a = 2'b10;
    wait_a("wd_regrant");
    chk("wd_regrant_ack", 32'(ack_a), 32'(2'b10));
`else
    regrant = 0;
    while (ack_a == 2'b10 && n < 40) begin
      if (to_a != 1'b0) regrant++;
      n++;
      tick();
    end
    chk("nowd_len",   32'(n),       32'd40);
    chk("nowd_pulse", 32'(regrant), 32'd0);
`endif
    req_a = 2'b11;
    tick(12);

    // CPU_SLOT=0: back-to-back requests from master 0
    req_b = 2'b10;
    n = 0;
    while (ack_b == 2'b11 && n < 30) begin
      tick();
      n++;
    end
    chk("b_grant", 32'(ack_b), 32'(2'b10));
    tick();
    req_b = 2'b11;
    tick();
    chk("b_rel_ack",   32'(ack_b),   32'(2'b11));
    chk("b_rel_busrq", 32'(busrq_b), 32'd1);
    req_b = 2'b10;
    regrant = 0;
    while (busy_b && regrant < 20) begin
      tick();
      regrant++;
    end
    n = 0;
    while (!busy_b && n < 20) begin
      tick();
      n++;
    end
    chk("b_gap",   32'(n),       32'd1);
    chk("b_busrq", 32'(busrq_b), 32'd0);
    req_b = 2'b11;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
